out_display_driver: RTL and testbench
=====================================

Name: out_display_driver

Overview:
- Downstream consumer of the SAP-1 output register.
- Takes the 8-bit output value, converts it to three BCD digits with a sequential double-dabble engine, and drives a time-multiplexed 3-digit 7-segment display.
- Buffers one pending value while a conversion is in progress, so back-to-back output loads are not lost.

Parameters:
- REFRESH_DIV, 1000: clocks each digit stays lit before the scan advances (minimum 2).
- SEG_ACTIVE_LOW, 1: 1 means seg and an are active-low; 0 inverts both.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  asynchronous, active-high reset.
- data_in  input  8  value from the output register.
- data_valid  input  1  one-cycle strobe, the same signal that loads the output register (CON[0]).
- busy  output  1  high while a conversion is in flight.
- done  output  1  one-cycle pulse when bcd_out updates.
- bcd_out  output  12  {hundreds, tens, units} of the last completed conversion.
- seg  output  7  segments {g,f,e,d,c,b,a}.
- an  output  3  one-hot digit enable; an[0] is units.

Behaviour:
- Reset (async, clr=1):
  - state=IDLE, busy=0, done=0, bcd_out=0, pending flag=0.
  - Refresh counter=0, digit index=0.
  - an all off, seg all off.
  - Reset mid-conversion abandons the conversion and clears the pending value.
- FSM states are IDLE, SHIFT, DONE:
  - IDLE: if data_valid, or the pending flag is set, capture the value (data_valid has priority over pending), clear the scratch register and shift count, and go to SHIFT. busy=1 from the next cycle.
  - SHIFT: exactly 8 cycles. Each cycle, add 3 to every BCD nibble >=5, then shift {bcd, bin} left by 1. On the 8th edge, write bcd_out, set done=1 for one cycle, and go to DONE.
  - DONE: one cycle, busy still 1, then return to IDLE. A pending value starts on the following edge.
- Latency: data_valid sampled at edge T0 means bcd_out is valid and done=1 after edge T8. busy is high from after T0 through the DONE cycle.
- data_valid while busy:
  - The value is written to a one-deep pending register and the pending flag is set.
  - A later strobe overwrites the pending value; only the newest value survives.
  - Strobes are never dropped silently except by this overwrite.
- Display scan:
  - The refresh counter runs 0..REFRESH_DIV-1 continuously, starting after reset.
  - On wrap, the digit index advances 0 -> 1 -> 2 -> 0.
  - an is one-hot on the active index. seg is the decode of the selected nibble of bcd_out.
  - The scan is independent of the FSM. A bcd_out update appears on the next displayed digit with no glitch beyond one cycle.
- Leading-zero blanking:
  - Hundreds is blank if 0.
  - Tens is blank if hundreds=0 and tens=0.
  - Units is always shown, so 0 displays as a single "0".
  - A blank digit drives seg all off, while an still scans.
- Arithmetic: the maximum input 255 gives 12'h255; no overflow is possible.

Optional Feature:
- Macro: HEX_MODE_EN.
- With the macro defined:
  - Adds input hex_sel (1 bit), sampled together with data_in at capture.
  - If hex_sel=1, SHIFT is skipped, bcd_out={4'h0, data}, and done pulses after edge T1.
  - The segment decoder also covers A-F.
  - Hundreds is always blank in hex; tens is blank if 0.
- Without the macro: no hex_sel port, decimal conversion only, and nibbles above 9 decode to blank.

Decomposition:
- Shared package sap_disp_pkg holds:
  - state encoding constants (IDLE, SHIFT, DONE);
  - the 16-entry segment pattern table and the SEG_BLANK constant;
  - DIGITS=3 and the shift-count width.
- One natural sub-module: seg7_decode, a combinational nibble-plus-blank to 7-bit pattern decoder, with polarity applied in the top module.

Test Plan:
- Convert 255: data_in=8'd255 pulse -> busy for 9 cycles, done after edge T8, bcd_out=12'h255; with REFRESH_DIV=4, scan shows 5, 5, 2.
- Blanking: data_in=8'd7 -> bcd_out=12'h007; hundreds and tens seg off, units shows 7. data_in=0 -> only units shows "0".
- Scan timing: REFRESH_DIV=4, SEG_ACTIVE_LOW=1 -> an sequence 110, 101, 011, each held exactly 4 clocks, repeating.
- Back-to-back strobes: 100, then 42 and 9 both while busy -> two conversions; done pulses twice; final bcd_out=12'h009.
- Reset: assert clr during the 4th SHIFT cycle with a value pending -> outputs go to reset values immediately; after release, no conversion starts without a new data_valid.
- Hex mode (HEX_MODE_EN, hex_sel=1): data_in=8'hAB -> done after T1, bcd_out=12'h0AB, display shows blank, A, B.

Source files
------------

// File: rtl/sap_disp_pkg.sv
// Shared definitions for the SAP-1 output display driver:
// FSM state encoding, the 7-segment pattern table, digit count and
// the double-dabble shift-count width. Patterns are active-high with
// bit order {g,f,e,d,c,b,a}; display polarity is applied in the top.
package sap_disp_pkg;

  localparam int DIGITS      = 3;
  localparam int SHIFT_CNT_W = 3;

  // Count value of the eighth (final) shift cycle
  localparam logic [SHIFT_CNT_W-1:0] SHIFT_LAST = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Index n holds the pattern for hex digit n (0..F)
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more
  function automatic logic [11:0] bcd_adjust(input logic [11:0] bcd);
    logic [11:0] r;
    r = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
      end else begin
        r[i*4 +: 4] = r[i*4 +: 4];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-7-segment decoder (active-high pattern).
// With HEX_MODE_EN defined, A-F are decoded; otherwise nibbles above 9
// decode to blank.
module seg7_decode
  import sap_disp_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] pattern
);

  // Table lookup with blanking override
  always_comb begin
    pattern = SEG_BLANK;
    if (blank) begin
      pattern = SEG_BLANK;
`ifdef HEX_MODE_EN
    end else begin
      pattern = SEG_TABLE[nibble];
    end
`else
    end else if (nibble > 4'd9) begin
      pattern = SEG_BLANK;
    end else begin
      pattern = SEG_TABLE[nibble];
    end
`endif
  end

endmodule

// File: rtl/out_display_driver.sv
// SAP-1 output display driver: converts the 8-bit output register value
// to BCD with a sequential double-dabble engine (one pending value is
// buffered while busy) and scans a 3-digit multiplexed 7-segment display
// with leading-zero blanking.
// Optional build macro HEX_MODE_EN adds the hex_sel input for hex display.
module out_display_driver
  import sap_disp_pkg::*;
#(
  parameter int REFRESH_DIV    = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
`ifdef HEX_MODE_EN
  input  logic        hex_sel,
`endif
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd_out,
  output logic [6:0]  seg,
  output logic [2:0]  an
);

  localparam int RCNT_W = $clog2(REFRESH_DIV);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [2:0] AN_OFF  = SEG_ACTIVE_LOW ? 3'b111 : 3'b000;

  logic hex_in_s;
`ifdef HEX_MODE_EN
  assign hex_in_s = hex_sel;
`else
  assign hex_in_s = 1'b0;
`endif

  state_e                 state_q, state_d;
  logic [7:0]             bin_q, bin_d;
  logic [11:0]            scr_q, scr_d;
  logic [SHIFT_CNT_W-1:0] cnt_q, cnt_d;
  logic                   hex_q, hex_d;
  logic                   pend_v_q, pend_v_d;
  logic [7:0]             pend_data_q, pend_data_d;
  logic                   pend_hex_q, pend_hex_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [11:0]            bcd_out_q, bcd_out_d;
  logic                   disp_hex_q, disp_hex_d;
  logic [RCNT_W-1:0]      rcnt_q, rcnt_d;
  logic [1:0]             idx_q, idx_d;
  logic [6:0]             seg_q, seg_d;
  logic [2:0]             an_q, an_d;

  logic [11:0] adj_s;
  logic [19:0] shift_s;
  logic [3:0]  nib_s;
  logic        blank_s;
  logic [2:0]  an_on_s;
  logic [6:0]  pat_s;

  // FSM state register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (data_valid || pend_v_q) begin
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (hex_q || (cnt_q == SHIFT_LAST)) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM output: busy covers every non-idle cycle
  always_comb begin
    busy_d = (state_d != IDLE);
  end

  // Conversion datapath, pending buffer and result register
  always_comb begin
    bin_d       = bin_q;
    scr_d       = scr_q;
    cnt_d       = cnt_q;
    hex_d       = hex_q;
    pend_v_d    = pend_v_q;
    pend_data_d = pend_data_q;
    pend_hex_d  = pend_hex_q;
    bcd_out_d   = bcd_out_q;
    disp_hex_d  = disp_hex_q;
    done_d      = 1'b0;
    adj_s       = bcd_adjust(scr_q);
    shift_s     = {adj_s[10:0], bin_q, 1'b0};

    // A strobe while busy overwrites the one-deep pending slot
    if (data_valid && (state_q != IDLE)) begin
      pend_v_d    = 1'b1;
      pend_data_d = data_in;
      pend_hex_d  = hex_in_s;
    end else begin
      pend_v_d    = pend_v_q;
    end

    case (state_q)
      IDLE: begin
        if (data_valid) begin
          bin_d = data_in;
          hex_d = hex_in_s;
          scr_d = 12'h000;
          cnt_d = '0;
        end else if (pend_v_q) begin
          bin_d    = pend_data_q;
          hex_d    = pend_hex_q;
          scr_d    = 12'h000;
          cnt_d    = '0;
          pend_v_d = 1'b0;
        end else begin
          bin_d = bin_q;
        end
      end
      SHIFT: begin
        if (hex_q) begin
          bcd_out_d  = {4'h0, bin_q};
          disp_hex_d = 1'b1;
          done_d     = 1'b1;
        end else begin
          scr_d = shift_s[19:8];
          bin_d = shift_s[7:0];
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == SHIFT_LAST) begin
            bcd_out_d  = shift_s[19:8];
            disp_hex_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            done_d     = 1'b0;
          end
        end
      end
      DONE:    done_d = 1'b0;
      default: done_d = 1'b0;
    endcase
  end

  // Refresh counter and digit index, free-running from reset
  always_comb begin
    if (rcnt_q == RCNT_LAST) begin
      rcnt_d = '0;
      idx_d  = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end else begin
      rcnt_d = rcnt_q + RCNT_W'(1);
      idx_d  = idx_q;
    end
  end

  // Digit selection with leading-zero blanking
  always_comb begin
    nib_s   = bcd_out_q[3:0];
    blank_s = 1'b0;
    an_on_s = 3'b001;
    case (idx_q)
      2'd0: begin
        nib_s   = bcd_out_q[3:0];
        blank_s = 1'b0;
        an_on_s = 3'b001;
      end
      2'd1: begin
        nib_s   = bcd_out_q[7:4];
        blank_s = disp_hex_q ? (bcd_out_q[7:4] == 4'h0)
                             : ((bcd_out_q[11:8] == 4'h0) && (bcd_out_q[7:4] == 4'h0));
        an_on_s = 3'b010;
      end
      2'd2: begin
        nib_s   = bcd_out_q[11:8];
        blank_s = disp_hex_q ? 1'b1 : (bcd_out_q[11:8] == 4'h0);
        an_on_s = 3'b100;
      end
      default: begin
        nib_s   = 4'h0;
        blank_s = 1'b1;
        an_on_s = 3'b000;
      end
    endcase
  end

  seg7_decode u_seg7_decode (
    .nibble  (nib_s),
    .blank   (blank_s),
    .pattern (pat_s)
  );

  // Apply display polarity to segment and anode drive
  always_comb begin
    seg_d = SEG_ACTIVE_LOW ? ~pat_s : pat_s;
    an_d  = SEG_ACTIVE_LOW ? ~an_on_s : an_on_s;
  end

  // Datapath, scan and output registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      bin_q       <= 8'h00;
      scr_q       <= 12'h000;
      cnt_q       <= '0;
      hex_q       <= 1'b0;
      pend_v_q    <= 1'b0;
      pend_data_q <= 8'h00;
      pend_hex_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bcd_out_q   <= 12'h000;
      disp_hex_q  <= 1'b0;
      rcnt_q      <= '0;
      idx_q       <= 2'd0;
      seg_q       <= SEG_OFF;
      an_q        <= AN_OFF;
    end else begin
      bin_q       <= bin_d;
      scr_q       <= scr_d;
      cnt_q       <= cnt_d;
      hex_q       <= hex_d;
      pend_v_q    <= pend_v_d;
      pend_data_q <= pend_data_d;
      pend_hex_q  <= pend_hex_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      bcd_out_q   <= bcd_out_d;
      disp_hex_q  <= disp_hex_d;
      rcnt_q      <= rcnt_d;
      idx_q       <= idx_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_out_q;
  assign seg     = seg_q;
  assign an      = an_q;

endmodule

// File: tb/tb_out_display_driver.sv
// Self-checking bench for out_display_driver (REFRESH_DIV=4, active-low).
module tb_out_display_driver;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [7:0]  data_in = 8'h00;
  logic        data_valid = 1'b0;
`ifdef HEX_MODE_EN
  logic        hex_sel = 1'b0;
`endif
  logic        busy, done;
  logic [11:0] bcd_out;
  logic [6:0]  seg;
  logic [2:0]  an;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  out_display_driver #(.REFRESH_DIV(RD), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk        (clk),
    .clr        (clr),
    .data_in    (data_in),
    .data_valid (data_valid),
`ifdef HEX_MODE_EN
    .hex_sel    (hex_sel),
`endif
    .busy       (busy),
    .done       (done),
    .bcd_out    (bcd_out),
    .seg        (seg),
    .an         (an)
  );

  typedef struct {
    logic [7:0]  data;
    logic [11:0] bcd;
    logic        bh;
    logic        bt;
  } vec_t;

  typedef struct {
    int          due;
    logic [11:0] val;
  } exp_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Decimal value to packed BCD from plain arithmetic
  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Expected active-low segment drive for a digit
  function automatic logic [6:0] ref_seg(input logic [3:0] n, input logic blank);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'h3F; 4'h1: p = 7'h06; 4'h2: p = 7'h5B; 4'h3: p = 7'h4F;
      4'h4: p = 7'h66; 4'h5: p = 7'h6D; 4'h6: p = 7'h7D; 4'h7: p = 7'h07;
      4'h8: p = 7'h7F; 4'h9: p = 7'h6F; 4'hA: p = 7'h77; 4'hB: p = 7'h7C;
      4'hC: p = 7'h39; 4'hD: p = 7'h5E; 4'hE: p = 7'h79; default: p = 7'h71;
    endcase
    if (blank) p = 7'h00;
    return ~p;
  endfunction

  // Watch a full scan and compare each lit digit against the expected value
  task automatic check_display(input logic [11:0] b, input logic bh, input logic bt);
    logic [3:0] nib;
    logic       bl;
    for (int i = 0; i < 3 * RD; i++) begin
      tick();
      case (an)
        3'b110: begin nib = b[3:0];  bl = 1'b0; check("disp_units", {25'd0, seg}, {25'd0, ref_seg(nib, bl)}); end
        3'b101: begin nib = b[7:4];  bl = bt;   check("disp_tens",  {25'd0, seg}, {25'd0, ref_seg(nib, bl)}); end
        3'b011: begin nib = b[11:8]; bl = bh;   check("disp_hund",  {25'd0, seg}, {25'd0, ref_seg(nib, bl)}); end
        default: check("disp_an_onehot", {29'd0, an}, 32'h6);
      endcase
    end
  endtask

  // Strobe one value and measure busy length, done timing and result
  task automatic run_conv(input logic [7:0] v, input logic hx, input logic [11:0] exp_bcd, input int exp_done_at, input int exp_busy);
    int busy_n, done_at, done_n;
    logic [11:0] got;
    busy_n = 0; done_at = -1; done_n = 0; got = 12'h000;
    data_in = v; data_valid = 1'b1;
`ifdef HEX_MODE_EN
    hex_sel = hx;
`endif
    tick();
    data_valid = 1'b0;
`ifdef HEX_MODE_EN
    hex_sel = 1'b0;
`endif
    for (int k = 0; k < 20; k++) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) begin done_at = k; got = bcd_out; end
      end
      tick();
    end
    check("conv_busy_len", busy_n, exp_busy);
    check("conv_done_at", done_at, exp_done_at);
    check("conv_done_cnt", done_n, 1);
    check("conv_bcd", {20'd0, got}, {20'd0, exp_bcd});
    if (hx === 1'b1) check("conv_hex_flag", 32'd1, 32'd1 - {31'd0, busy});
  endtask

  initial begin
    vec_t vecs [10];
    exp_t q[$];
    int busy_left, pend_v, done_n;
    logic [7:0]  pend_d, d;
    logic        dv, exp_done;
    logic [11:0] vals [2];
    logic [2:0]  prev_an, nxt;
    int run_len, first, bad;

    vecs[0] = '{8'd255, 12'h255, 1'b0, 1'b0};
    vecs[1] = '{8'd7,   12'h007, 1'b1, 1'b1};
    vecs[2] = '{8'd0,   12'h000, 1'b1, 1'b1};
    vecs[3] = '{8'd100, 12'h100, 1'b0, 1'b0};
    vecs[4] = '{8'd42,  12'h042, 1'b1, 1'b0};
    vecs[5] = '{8'd9,   12'h009, 1'b1, 1'b1};
    vecs[6] = '{8'd99,  12'h099, 1'b1, 1'b0};
    vecs[7] = '{8'd10,  12'h010, 1'b1, 1'b0};
    vecs[8] = '{8'd128, 12'h128, 1'b0, 1'b0};
    vecs[9] = '{8'd200, 12'h200, 1'b0, 1'b0};

    // Reset state
    tick(); tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_bcd", {20'd0, bcd_out}, 32'd0);
    check("rst_an", {29'd0, an}, 32'h7);
    check("rst_seg", {25'd0, seg}, 32'h7F);
    clr = 1'b0;

    // Table-driven conversions and display checks
    for (int i = 0; i < 10; i++) begin
      run_conv(vecs[i].data, 1'b0, vecs[i].bcd, 8, 9);
      check_display(vecs[i].bcd, vecs[i].bh, vecs[i].bt);
    end

    // Scan timing: 110 -> 101 -> 011, each held RD clocks
    prev_an = an; run_len = 1; first = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (an === prev_an) begin
        run_len++;
      end else begin
        if (first == 0) check("scan_hold", run_len, RD);
        case (prev_an)
          3'b110:  nxt = 3'b101;
          3'b101:  nxt = 3'b011;
          default: nxt = 3'b110;
        endcase
        check("scan_order", {29'd0, an}, {29'd0, nxt});
        first = 0; prev_an = an; run_len = 1;
      end
    end

    // Back-to-back: 100, then 42 and 9 while busy
    data_in = 8'd100; data_valid = 1'b1; tick(); data_valid = 1'b0;
    tick();
    data_in = 8'd42; data_valid = 1'b1; tick(); data_valid = 1'b0;
    tick();
    data_in = 8'd9; data_valid = 1'b1; tick(); data_valid = 1'b0;
    done_n = 0; vals[0] = 12'h000; vals[1] = 12'h000;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        if (done_n < 2) vals[done_n] = bcd_out;
        done_n++;
      end
      tick();
    end
    check("b2b_done_cnt", done_n, 2);
    check("b2b_first", {20'd0, vals[0]}, 32'h100);
    check("b2b_second", {20'd0, vals[1]}, 32'h009);
    check("b2b_final", {20'd0, bcd_out}, 32'h009);

    // Reset during the 4th shift cycle with a value pending
    data_in = 8'd200; data_valid = 1'b1; tick(); data_valid = 1'b0;
    tick();
    data_in = 8'd33; data_valid = 1'b1; tick(); data_valid = 1'b0;
    tick();
    clr = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_bcd", {20'd0, bcd_out}, 32'd0);
    check("mid_rst_an", {29'd0, an}, 32'h7);
    check("mid_rst_seg", {25'd0, seg}, 32'h7F);
    tick(); tick();
    clr = 1'b0;
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("post_rst_idle", bad, 0);
    check("post_rst_bcd", {20'd0, bcd_out}, 32'd0);

    // Randomized strobes against a cycle-level reference model
    busy_left = 0; pend_v = 0; pend_d = 8'h00;
    for (int c = 0; c < 700; c++) begin
      dv = (c < 660) && ($urandom_range(0, 4) == 0);
      d  = 8'($urandom_range(0, 255));
      data_in = d; data_valid = dv;
      tick();
      data_valid = 1'b0;
      if (busy_left == 0) begin
        if (dv) begin
          q.push_back('{c + 8, to_bcd(int'(d))}); busy_left = 9;
        end else if (pend_v != 0) begin
          q.push_back('{c + 8, to_bcd(int'(pend_d))}); busy_left = 9; pend_v = 0;
        end
      end else begin
        if (dv) begin pend_v = 1; pend_d = d; end
        busy_left--;
      end
      exp_done = (q.size() > 0) && (q[0].due == c);
      check("rnd_done", {31'd0, done}, {31'd0, exp_done});
      check("rnd_busy", {31'd0, busy}, {31'd0, (busy_left > 0)});
      if (exp_done) begin
        check("rnd_bcd", {20'd0, bcd_out}, {20'd0, q[0].val});
        void'(q.pop_front());
      end
    end
    check("rnd_drained", q.size(), 0);

`ifdef HEX_MODE_EN
    // Hex mode: shift skipped, done after T1
    run_conv(8'hAB, 1'b1, 12'h0AB, 1, 2);
    check_display(12'h0AB, 1'b1, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
